id_ex_hazard_reg: RTL and testbench

// ID/EX pipeline register with load-use hazard detection for the 5-stage LEGv8 pipeline.
// - Captures decoded operands/control from ID and drives the EX stage, including Rn_EX and Rm_EX

---
 rtl/id_ex_hazard_reg_if.sv | 48 ++++
 rtl/id_ex_hazard_reg.sv | 96 +++++++++
 tb/tb_id_ex_hazard_reg.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_hazard_reg_if.sv
// rtl/id_ex_hazard_reg_if.sv - ID-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_hazard_reg_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic              valid_ID;
    logic [4:0]        Rn_ID;
    logic [4:0]        Rm_ID;
    logic              usesRm_ID;
    logic [4:0]        Rd_ID;
    logic              RegWrite_ID;
    logic              MemRead_ID;
    logic              MemWrite_ID;
    logic [CTRL_W-1:0] ctrl_ID;
    logic [DATA_W-1:0] opA_ID;
    logic [DATA_W-1:0] opB_ID;
    logic [DATA_W-1:0] imm_ID;
    logic              flush_EX;

    logic              valid_EX;
    logic [4:0]        Rn_EX;
    logic [4:0]        Rm_EX;
    logic [4:0]        Rd_EX;
    logic              RegWrite_EX;
    logic              MemRead_EX;
    logic              MemWrite_EX;
    logic [CTRL_W-1:0] ctrl_EX;
    logic [DATA_W-1:0] opA_EX;
    logic [DATA_W-1:0] opB_EX;
    logic [DATA_W-1:0] imm_EX;
    logic              stall_IFID;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output valid_ID, Rn_ID, Rm_ID, usesRm_ID, Rd_ID, RegWrite_ID, MemRead_ID, MemWrite_ID,
        output ctrl_ID, opA_ID, opB_ID, imm_ID, flush_EX,
        input  valid_EX, Rn_EX, Rm_EX, Rd_EX, RegWrite_EX, MemRead_EX, MemWrite_EX,
        input  ctrl_EX, opA_EX, opB_EX, imm_EX, stall_IFID, stall_cnt
    );

    modport slave (
        input  valid_ID, Rn_ID, Rm_ID, usesRm_ID, Rd_ID, RegWrite_ID, MemRead_ID, MemWrite_ID,
        input  ctrl_ID, opA_ID, opB_ID, imm_ID, flush_EX,
        output valid_EX, Rn_EX, Rm_EX, Rd_EX, RegWrite_EX, MemRead_EX, MemWrite_EX,
        output ctrl_EX, opA_EX, opB_EX, imm_EX, stall_IFID, stall_cnt
    );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// rtl/id_ex_hazard_reg.sv - ID/EX pipeline register with load-use stall, flush squash and stall counter
module id_ex_hazard_reg #(
    parameter int DATA_W   = 64,
    parameter int CTRL_W   = 8,
    parameter int CNT_W    = 16,
    parameter int ZERO_REG = 31
) (
    input  logic                clk,
    input  logic                rst_n,
    id_ex_hazard_reg_if.slave   bus
);
    localparam logic [4:0] ZR = 5'(ZERO_REG);

    logic              r_valid;
    logic [4:0]        r_rn;
    logic [4:0]        r_rm;
    logic [4:0]        r_rd;
    logic              r_regwrite;
    logic              r_memread;
    logic              r_memwrite;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [DATA_W-1:0] r_imm;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_rn_match;
    logic w_rm_match;
    logic w_haz;
    logic w_stall;
    logic w_bubble;

    // Only a load already in EX can produce data too late for forwarding.
    assign w_rn_match = (r_rd == bus.Rn_ID);
    assign w_rm_match = bus.usesRm_ID & (r_rd == bus.Rm_ID);
    assign w_haz      = r_valid & r_memread & (r_rd != ZR) & bus.valid_ID & (w_rn_match | w_rm_match);
    assign w_stall    = w_haz & ~bus.flush_EX;
    assign w_bubble   = bus.flush_EX | w_haz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_rn        <= ZR;
            r_rm        <= ZR;
            r_rd        <= ZR;
            r_regwrite  <= 1'b0;
            r_memread   <= 1'b0;
            r_memwrite  <= 1'b0;
            r_ctrl      <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_imm       <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_bubble) begin
                // Operand fields are left as-is; a bubble never writes anything.
                r_valid    <= 1'b0;
                r_rn       <= ZR;
                r_rm       <= ZR;
                r_rd       <= ZR;
                r_regwrite <= 1'b0;
                r_memread  <= 1'b0;
                r_memwrite <= 1'b0;
            end else begin
                r_valid    <= bus.valid_ID;
                r_rn       <= bus.Rn_ID;
                r_rm       <= bus.Rm_ID;
                r_rd       <= bus.Rd_ID;
                r_regwrite <= bus.valid_ID & bus.RegWrite_ID;
                r_memread  <= bus.valid_ID & bus.MemRead_ID;
                r_memwrite <= bus.valid_ID & bus.MemWrite_ID;
                r_ctrl     <= bus.ctrl_ID;
                r_opa      <= bus.opA_ID;
                r_opb      <= bus.opB_ID;
                r_imm      <= bus.imm_ID;
            end
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.valid_EX    = r_valid;
    assign bus.Rn_EX       = r_rn;
    assign bus.Rm_EX       = r_rm;
    assign bus.Rd_EX       = r_rd;
    assign bus.RegWrite_EX = r_regwrite;
    assign bus.MemRead_EX  = r_memread;
    assign bus.MemWrite_EX = r_memwrite;
    assign bus.ctrl_EX     = r_ctrl;
    assign bus.opA_EX      = r_opa;
    assign bus.opB_EX      = r_opb;
    assign bus.imm_EX      = r_imm;
    assign bus.stall_IFID  = w_stall;
    assign bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// tb/tb_id_ex_hazard_reg.sv - self-checking bench for id_ex_hazard_reg against an instruction-level model
module tb_id_ex_hazard_reg;
    typedef struct packed {
        logic        v;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [7:0]  ctrl;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] imm;
    } ex_t;

    typedef struct packed {
        logic        v;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic        urm;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [7:0]  ctrl;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] imm;
    } id_t;

    logic clk;
    logic rst_n;

    id_ex_hazard_reg_if #(.DATA_W(64), .CTRL_W(8), .CNT_W(16)) bus ();
    id_ex_hazard_reg_if #(.DATA_W(64), .CTRL_W(8), .CNT_W(4))  sbus ();

    id_ex_hazard_reg #(.DATA_W(64), .CTRL_W(8), .CNT_W(16), .ZERO_REG(31)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    id_ex_hazard_reg #(.DATA_W(64), .CTRL_W(8), .CNT_W(4), .ZERO_REG(31)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    ex_t         m_ex;
    logic [15:0] m_cnt;
    logic [3:0]  s_cnt;
    id_t         cur_id;
    logic        cur_fl;
    id_t         s_id;

    function automatic ex_t ex_reset();
        ex_t e;
        e = '0;
        e.rn = 5'd31;
        e.rm = 5'd31;
        e.rd = 5'd31;
        return e;
    endfunction

    function automatic id_t id_idle();
        return '0;
    endfunction

    function automatic id_t mk(input logic v, input int rn, input int rm, input logic urm,
                               input int rd, input logic rw, input logic mr, input logic mw);
        id_t d;
        d.v    = v;
        d.rn   = 5'(rn);
        d.rm   = 5'(rm);
        d.urm  = urm;
        d.rd   = 5'(rd);
        d.rw   = rw;
        d.mr   = mr;
        d.mw   = mw;
        d.ctrl = 8'($urandom);
        d.a    = {$urandom, $urandom};
        d.b    = {$urandom, $urandom};
        d.imm  = {$urandom, $urandom};
        return d;
    endfunction

    // A load in EX blocks a consumer in ID that really reads its (non-XZR) destination.
    function automatic logic load_use(input ex_t e, input id_t d);
        if (!(e.v && e.mr) || e.rd == 5'd31 || !d.v) return 1'b0;
        if (d.rn == e.rd) return 1'b1;
        return d.urm && (d.rm == e.rd);
    endfunction

    function automatic ex_t dut_ex();
        ex_t e;
        e.v    = bus.valid_EX;
        e.rn   = bus.Rn_EX;
        e.rm   = bus.Rm_EX;
        e.rd   = bus.Rd_EX;
        e.rw   = bus.RegWrite_EX;
        e.mr   = bus.MemRead_EX;
        e.mw   = bus.MemWrite_EX;
        e.ctrl = bus.ctrl_EX;
        e.a    = bus.opA_EX;
        e.b    = bus.opB_EX;
        e.imm  = bus.imm_EX;
        return e;
    endfunction

    task automatic drive(input id_t d, input logic fl);
        cur_id          = d;
        cur_fl          = fl;
        bus.valid_ID    = d.v;
        bus.Rn_ID       = d.rn;
        bus.Rm_ID       = d.rm;
        bus.usesRm_ID   = d.urm;
        bus.Rd_ID       = d.rd;
        bus.RegWrite_ID = d.rw;
        bus.MemRead_ID  = d.mr;
        bus.MemWrite_ID = d.mw;
        bus.ctrl_ID     = d.ctrl;
        bus.opA_ID      = d.a;
        bus.opB_ID      = d.b;
        bus.imm_ID      = d.imm;
        bus.flush_EX    = fl;
        #1;
    endtask

    task automatic sdrive(input id_t d);
        s_id             = d;
        sbus.valid_ID    = d.v;
        sbus.Rn_ID       = d.rn;
        sbus.Rm_ID       = d.rm;
        sbus.usesRm_ID   = d.urm;
        sbus.Rd_ID       = d.rd;
        sbus.RegWrite_ID = d.rw;
        sbus.MemRead_ID  = d.mr;
        sbus.MemWrite_ID = d.mw;
        sbus.ctrl_ID     = d.ctrl;
        sbus.opA_ID      = d.a;
        sbus.opB_ID      = d.b;
        sbus.imm_ID      = d.imm;
        sbus.flush_EX    = 1'b0;
    endtask

    // Advances one edge; the main model follows the instruction flow, s_cnt follows the small instance.
    task automatic advance(input logic s_stall);
        logic haz;
        haz = load_use(m_ex, cur_id);
        @(posedge clk);
        if (haz && !cur_fl && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (s_stall && s_cnt != 4'hF) s_cnt = s_cnt + 4'd1;
        if (cur_fl || haz) begin
            m_ex.v  = 1'b0;
            m_ex.rn = 5'd31;
            m_ex.rm = 5'd31;
            m_ex.rd = 5'd31;
            m_ex.rw = 1'b0;
            m_ex.mr = 1'b0;
            m_ex.mw = 1'b0;
        end else begin
            m_ex.v    = cur_id.v;
            m_ex.rn   = cur_id.rn;
            m_ex.rm   = cur_id.rm;
            m_ex.rd   = cur_id.rd;
            m_ex.rw   = cur_id.v & cur_id.rw;
            m_ex.mr   = cur_id.v & cur_id.mr;
            m_ex.mw   = cur_id.v & cur_id.mw;
            m_ex.ctrl = cur_id.ctrl;
            m_ex.a    = cur_id.a;
            m_ex.b    = cur_id.b;
            m_ex.imm  = cur_id.imm;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(id_idle(), 1'b0);
        sdrive(id_idle());
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (dut_ex() !== ex_reset()) begin
            bad++;
            $display("FAIL reset_ex: got %h want %h", dut_ex(), ex_reset());
        end
        total++;
        if (bus.stall_cnt !== 16'd0 || sbus.stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.stall_cnt, sbus.stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_ex  = ex_reset();
        m_cnt = '0;
        s_cnt = '0;
        advance(1'b0);
    endtask

    task automatic test_pass_through();
        id_t d;
        d = mk(1'b1, 1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b0);
        d.a = 64'h10;
        d.b = 64'h20;
        drive(d, 1'b0);
        total++;
        if (bus.stall_IFID !== 1'b0) begin
            bad++;
            $display("FAIL pass_stall: got %b want 0", bus.stall_IFID);
        end
        advance(1'b0);
        total++;
        if (dut_ex() !== m_ex || bus.Rd_EX !== 5'd3 || bus.opA_EX !== 64'h10 || bus.opB_EX !== 64'h20) begin
            bad++;
            $display("FAIL pass_ex: got %h want %h", dut_ex(), m_ex);
        end
    endtask

    task automatic test_load_use_rn();
        id_t add;
        logic [15:0] c0;
        c0 = m_cnt;
        drive(mk(1'b1, 1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0), 1'b0);
        advance(1'b0);
        add = mk(1'b1, 5, 6, 1'b1, 8, 1'b1, 1'b0, 1'b0);
        drive(add, 1'b0);
        total++;
        if (bus.stall_IFID !== 1'b1) begin
            bad++;
            $display("FAIL lu_stall: got %b want 1", bus.stall_IFID);
        end
        advance(1'b0);
        total++;
        if (bus.valid_EX !== 1'b0 || bus.Rd_EX !== 5'd31 || dut_ex() !== m_ex) begin
            bad++;
            $display("FAIL lu_bubble: got %h want %h", dut_ex(), m_ex);
        end
        total++;
        if (bus.stall_cnt !== c0 + 16'd1) begin
            bad++;
            $display("FAIL lu_cnt: got %0d want %0d", bus.stall_cnt, c0 + 16'd1);
        end
        drive(add, 1'b0);
        total++;
        if (bus.stall_IFID !== 1'b0) begin
            bad++;
            $display("FAIL lu_release: got %b want 0", bus.stall_IFID);
        end
        advance(1'b0);
        total++;
        if (dut_ex() !== m_ex || bus.Rn_EX !== 5'd5) begin
            bad++;
            $display("FAIL lu_enter: got %h want %h", dut_ex(), m_ex);
        end
    endtask

    task automatic test_rm_false_hazard();
        drive(mk(1'b1, 0, 0, 1'b0, 7, 1'b1, 1'b1, 1'b0), 1'b0);
        advance(1'b0);
        drive(mk(1'b1, 2, 7, 1'b0, 9, 1'b0, 1'b0, 1'b1), 1'b0);
        total++;
        if (bus.stall_IFID !== 1'b0) begin
            bad++;
            $display("FAIL rm_unused: got %b want 0", bus.stall_IFID);
        end
        drive(mk(1'b1, 2, 7, 1'b1, 9, 1'b1, 1'b0, 1'b0), 1'b0);
        total++;
        if (bus.stall_IFID !== 1'b1) begin
            bad++;
            $display("FAIL rm_used: got %b want 1", bus.stall_IFID);
        end
        advance(1'b0);
    endtask

    task automatic test_xzr_flush();
        logic [15:0] c0;
        drive(mk(1'b1, 0, 0, 1'b0, 31, 1'b1, 1'b1, 1'b0), 1'b0);
        advance(1'b0);
        drive(mk(1'b1, 31, 31, 1'b1, 4, 1'b1, 1'b0, 1'b0), 1'b0);
        total++;
        if (bus.stall_IFID !== 1'b0) begin
            bad++;
            $display("FAIL xzr_stall: got %b want 0", bus.stall_IFID);
        end
        drive(mk(1'b1, 0, 0, 1'b0, 12, 1'b1, 1'b1, 1'b0), 1'b0);
        advance(1'b0);
        c0 = m_cnt;
        drive(mk(1'b1, 12, 3, 1'b1, 13, 1'b1, 1'b0, 1'b0), 1'b1);
        total++;
        if (bus.stall_IFID !== 1'b0) begin
            bad++;
            $display("FAIL flush_stall: got %b want 0", bus.stall_IFID);
        end
        advance(1'b0);
        total++;
        if (bus.valid_EX !== 1'b0 || bus.Rd_EX !== 5'd31 || bus.stall_cnt !== c0 || dut_ex() !== m_ex) begin
            bad++;
            $display("FAIL flush_bubble: got %h cnt %0d want %h cnt %0d", dut_ex(), bus.stall_cnt, m_ex, c0);
        end
    endtask

    task automatic test_random();
        id_t  d;
        logic held;
        logic exp;
        int   r[3];
        held = 1'b0;
        d    = id_idle();
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                for (int k = 0; k < 3; k++) begin
                    r[k] = int'($urandom_range(0, 8));
                    if (r[k] == 8) r[k] = 31;
                end
                d = mk(($urandom % 5) != 0, r[0], r[1], 1'($urandom), r[2],
                       1'($urandom), ($urandom % 3) == 0, 1'($urandom));
            end
            drive(d, ($urandom % 10) == 0);
            exp = load_use(m_ex, cur_id) && !cur_fl;
            total++;
            if (bus.stall_IFID !== exp) begin
                bad++;
                $display("FAIL rnd_stall[%0d]: got %b want %b", i, bus.stall_IFID, exp);
            end
            if (held) begin
                total++;
                if (bus.stall_IFID !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_double_stall[%0d]: got 1 want 0", i);
                end
            end
            held = exp;
            advance(1'b0);
            total++;
            if (dut_ex() !== m_ex || bus.stall_cnt !== m_cnt) begin
                bad++;
                $display("FAIL rnd_ex[%0d]: got %h cnt %0d want %h cnt %0d", i, dut_ex(), bus.stall_cnt, m_ex, m_cnt);
            end
        end
    endtask

    task automatic test_saturation();
        drive(id_idle(), 1'b0);
        for (int i = 0; i < 20; i++) begin
            sdrive(mk(1'b1, 0, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0));
            advance(1'b0);
            sdrive(mk(1'b1, 5, 1, 1'b1, 6, 1'b1, 1'b0, 1'b0));
            #1;
            total++;
            if (sbus.stall_IFID !== 1'b1) begin
                bad++;
                $display("FAIL sat_stall[%0d]: got %b want 1", i, sbus.stall_IFID);
            end
            advance(1'b1);
            total++;
            if (sbus.stall_cnt !== s_cnt) begin
                bad++;
                $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, sbus.stall_cnt, s_cnt);
            end
        end
        total++;
        if (sbus.stall_cnt !== 4'd15) begin
            bad++;
            $display("FAIL sat_final: got %0d want 15", sbus.stall_cnt);
        end
        sdrive(id_idle());
    endtask

    task automatic test_reset_midstream();
        drive(mk(1'b1, 3, 4, 1'b1, 6, 1'b1, 1'b1, 1'b1), 1'b0);
        advance(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (dut_ex() !== ex_reset()) begin
            bad++;
            $display("FAIL midrst_ex: got %h want %h", dut_ex(), ex_reset());
        end
        total++;
        if (bus.stall_cnt !== 16'd0 || sbus.stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL midrst_cnt: got %0d/%0d want 0/0", bus.stall_cnt, sbus.stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_ex  = ex_reset();
        m_cnt = '0;
        s_cnt = '0;
        drive(id_idle(), 1'b0);
        advance(1'b0);
        total++;
        if (dut_ex() !== m_ex || bus.stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL midrst_after: got %h want %h", dut_ex(), m_ex);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_use_rn();
        test_rm_false_hazard();
        test_xzr_flush();
        test_random();
        test_saturation();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
